// File: rtl/id_stage.sv
// LEGv8 instruction-decode stage: opcode decode, 32x64 register file with
// write bypass, load-use hazard detection and the registered ID/EX buffer.
module id_stage (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [95:0]  if_buf,
   input  logic         if_valid,
   input  logic         flush,
   input  logic         wb_reg_write,
   input  logic [4:0]   wb_reg,
   input  logic [63:0]  wb_data,
   output logic [298:0] id_ex_buf,
   output logic         id_ex_valid,
   output logic         stall,
   output logic         illegal
);

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [7:0]  OP_CBNZ = 8'b10110101;
   localparam logic [5:0]  OP_B    = 6'b000101;

   logic [31:0] instr;
   logic [63:0] pc;
   logic [4:0]  rn, rm, rt;

   assign instr = if_buf[95:64];
   assign pc    = if_buf[63:0];
   assign rn    = instr[9:5];
   assign rm    = instr[20:16];
   assign rt    = instr[4:0];

   logic        is_r, is_imm, is_ldur, is_stur, is_cbz, is_cbnz, is_b;

   assign is_r    = (instr[31:21] == OP_ADD) || (instr[31:21] == OP_SUB) ||
                    (instr[31:21] == OP_AND) || (instr[31:21] == OP_ORR);
   assign is_imm  = (instr[31:22] == OP_ADDI) || (instr[31:22] == OP_SUBI);
   assign is_ldur = (instr[31:21] == OP_LDUR);
   assign is_stur = (instr[31:21] == OP_STUR);
   assign is_cbz  = (instr[31:24] == OP_CBZ);
   assign is_cbnz = (instr[31:24] == OP_CBNZ);
   assign is_b    = (instr[31:26] == OP_B);

   logic [1:0]  alu_src, alu_op;
   logic        br, bz, bnz, mem_write, mem_read, mem_to_reg, reg_write;
   logic [63:0] sext;
   logic        legal;
   logic        use_src2;
   logic [4:0]  src2;

   always_comb begin
      alu_src    = 2'b00;
      alu_op     = 2'b00;
      br         = 1'b0;
      bz         = 1'b0;
      bnz        = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      sext       = 64'd0;
      legal      = 1'b1;
      use_src2   = 1'b0;
      src2       = rm;
      if (is_r) begin
         alu_op    = 2'b10;
         reg_write = 1'b1;
         use_src2  = 1'b1;
      end else if (is_imm) begin
         alu_src   = 2'b10;
         alu_op    = 2'b10;
         reg_write = 1'b1;
         sext      = {52'd0, instr[21:10]};
      end else if (is_ldur) begin
         alu_src    = 2'b01;
         mem_read   = 1'b1;
         mem_to_reg = 1'b1;
         reg_write  = 1'b1;
         sext       = {{55{instr[20]}}, instr[20:12]};
      end else if (is_stur) begin
         alu_src   = 2'b01;
         mem_write = 1'b1;
         use_src2  = 1'b1;
         src2      = rt;
         sext      = {{55{instr[20]}}, instr[20:12]};
      end else if (is_cbz || is_cbnz) begin
         alu_op   = 2'b01;
         bz       = is_cbz;
         bnz      = is_cbnz;
         use_src2 = 1'b1;
         src2     = rt;
         sext     = {{45{instr[23]}}, instr[23:5]};
      end else if (is_b) begin
         alu_op = 2'b01;
         br     = 1'b1;
         sext   = {{38{instr[25]}}, instr[25:0]};
      end else begin
         legal = 1'b0;
      end
   end

   // XZR reads as zero; otherwise a same-cycle write-back is forwarded.
   logic [63:0] regs [0:31];
   logic [63:0] data1, src2_val, data2;

   assign data1    = (rn == 5'd31) ? 64'd0 :
                     (wb_reg_write && (wb_reg == rn)) ? wb_data : regs[rn];
   assign src2_val = (src2 == 5'd31) ? 64'd0 :
                     (wb_reg_write && (wb_reg == src2)) ? wb_data : regs[src2];
   assign data2    = use_src2 ? src2_val : 64'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
      end else if (wb_reg_write && (wb_reg != 5'd31)) begin
         regs[wb_reg] <= wb_data;
      end
   end

   // Upstream presents an instruction when if_valid is high; it is accepted on
   // any edge where stall is low, and held unchanged by upstream while stall is high.
   logic [4:0] ex_rt;
   assign ex_rt = id_ex_buf[68:64];
   assign stall = id_ex_valid && id_ex_buf[296] && (ex_rt != 5'd31) &&
                  ((ex_rt == rn) || (use_src2 && (ex_rt == src2))) && if_valid;

   logic [298:0] next_buf;
   assign next_buf = {reg_write, mem_to_reg, mem_read, mem_write, bnz, bz, br,
                      alu_op, alu_src, data2, data1, sext, instr, pc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex_buf   <= '0;
         id_ex_valid <= 1'b0;
         illegal     <= 1'b0;
      end else if (flush || stall || !if_valid) begin
         id_ex_buf   <= '0;
         id_ex_valid <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         id_ex_buf   <= next_buf;
         id_ex_valid <= legal;
         illegal     <= !legal;
      end
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage LEGv8 pipeline. Captures the IF/ID word, decodes the opcode into control bits, reads the 32×64 register file and sign-extends the immediate. Registers the 299-bit ID/EX buffer consumed by the execute stage. Also owns the write-back port of the register file and the load-use hazard detector that stalls fetch.

## Interface
Parameters:
- none; all widths are fixed by the pipeline buffer format.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock; every register updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- if_buf  in  96  IF/ID word: [63:0] PC of the instruction, [95:64] instruction
- if_valid  in  1  if_buf holds a real instruction
- flush  in  1  branch taken (PCSrc from the memory stage); squash the instruction in decode
- wb_reg_write  in  1  write-back enable
- wb_reg  in  5  write-back destination register
- wb_data  in  64  write-back data
- id_ex_buf  out  299  ID/EX buffer; layout given under Operation
- id_ex_valid  out  1  id_ex_buf holds a real instruction
- stall  out  1  load-use hazard; upstream holds PC and if_buf this cycle
- illegal  out  1  registered; the last decoded instruction had an unknown opcode

## Operation
- ID/EX buffer layout:
  - Address [63:0], Instruction [95:64], signExtInstr [159:96]
  - Data1 [223:160], Data2 [287:224]
  - ALUSrc [289:288], ALUOp [291:290]
  - B 292, BZ 293, BNZ 294, MemWrite 295, MemRead 296, MemtoReg 297, RegWrite 298
- Register fields: Rn = instr[9:5], Rm = instr[20:16], Rt = instr[4:0].
- Data1 = R[Rn].
- Data2 = R[Rm] for R-type; R[Rt] for STUR, CBZ and CBNZ; 0 otherwise.
- Decode: the first matching row wins. Every control bit not listed is 0.
  - R-type (instr[31:21] = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): ALUSrc 00, ALUOp 10, RegWrite. signExt = 0.
  - ADDI 1001000100 / SUBI 1101000100 (instr[31:22]): ALUSrc 10, ALUOp 10, RegWrite. signExt = zero-extended instr[21:10].
  - LDUR 11111000010: ALUSrc 01, ALUOp 00, MemRead, MemtoReg, RegWrite. signExt = sext(instr[20:12]).
  - STUR 11111000000: ALUSrc 01, ALUOp 00, MemWrite. signExt = sext(instr[20:12]).
  - CBZ 10110100 / CBNZ 10110101 (instr[31:24]): ALUSrc 00, ALUOp 01, BZ or BNZ. signExt = sext(instr[23:5]).
  - B 000101 (instr[31:26]): ALUOp 01, B. signExt = sext(instr[25:0]).
  - Anything else: all control bits 0, illegal = 1, id_ex_valid = 0.
- Register file: 32 × 64-bit registers.
  - X31 (XZR) always reads 0; writes to it are discarded.
  - Write on the rising edge when wb_reg_write = 1.
  - Reads are combinational with write bypass: if wb_reg_write = 1, wb_reg = read index and the index is not 31, the read returns wb_data in the same cycle.
- Load-use hazard: stall = 1 combinationally when all of the following hold:
  - id_ex_valid = 1
  - id_ex_buf[296] (MemRead) = 1
  - the Rt of the instruction in ID/EX (id_ex_buf[68:64]) ≠ 31
  - that Rt equals the current Rn, or equals the current second source register when the decoded instruction uses one
  - if_valid = 1
- Bubble: while stall = 1, the next ID/EX load has bits [298:288] = 0 and id_ex_valid = 0. The remaining fields are don't-care.

## Timing
- Decode latency is 1 cycle: if_buf sampled at edge N appears on id_ex_buf after edge N.
- Priority at each edge: rst_n low, then flush, then stall, then normal load.
- flush = 1 at an edge: control bits [298:288] = 0, id_ex_valid = 0, illegal = 0. The register-file write in the same edge still occurs.
- if_valid = 0: loads a bubble identical to the stall bubble.
- Simultaneous write-back and read of the same register: the decode sees the new value through the bypass; no extra stall.
- Reset mid-operation: takes effect immediately, with no clock needed.
  - id_ex_buf = 0, id_ex_valid = 0, illegal = 0, all 32 registers = 0.
  - stall is 0 while in reset.
- stall depends only on registered state and if_buf, so it settles within the same cycle; the hazard clears after exactly one bubble.

## Test plan
- Reset then ADDI X1,X31,#5 (0x910017E1) at PC 0x40: one edge later, id_ex_buf[63:0] = 0x40, ALUSrc = 10, ALUOp = 10, RegWrite = 1, signExt = 5, Data1 = 0, id_ex_valid = 1.
- Write-back bypass: wb_reg_write = 1, wb_reg = 2, wb_data = 0x1234 in the same cycle ADD X3,X2,X2 is in decode: Data1 = Data2 = 0x1234. A write to X31 followed by a read of it returns 0.
- Load-use: LDUR X4,[X5,#8] then ADD X6,X4,X1: stall = 1 for one cycle, one bubble (id_ex_valid = 0, bits [298:288] = 0), then ADD issues. Repeat with the load's Rt = 31: no stall.
- Branch decode: CBNZ X7,#-3 gives BNZ = 1, Data2 = R[7], signExt = 0xFFFF_FFFF_FFFF_FFFD. B #0x100 gives B = 1, signExt = 0x100.
- flush asserted while both a stall condition and an illegal opcode are present: output is a bubble with illegal = 0 and stall ignored. Opcode 0xFFFFFFFF without flush gives illegal = 1 and id_ex_valid = 0.
- rst_n pulsed low between clock edges mid-stream: all outputs and registers read 0 before the next edge, and decode resumes normally after release.
